// File: rtl/display_pkg.sv
// Shared digit types for the hex counter and the 7-segment decoder stage.
package display_pkg;
  localparam int DIGIT_W = 4;
  typedef logic [DIGIT_W-1:0] digit_t;
  localparam digit_t DIGIT_MAX = 4'hF;
endpackage

// File: rtl/hex_digit.sv
// One mod-16 up/down digit cell; load wins, otherwise steps when the carry reaches it.
// Registered digit, combinational carry-out into the next cell; no backpressure.
module hex_digit
  import display_pkg::*;
(
  input  logic   Clock,
  input  logic   Resetn,
  input  logic   i_load,
  input  digit_t i_load_val,
  input  logic   i_adv,
  input  logic   i_up,
  input  logic   i_cin,
  output digit_t o_digit,
  output logic   o_cout
);
  digit_t r_digit;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_digit <= '0;
    end else if (i_load) begin
      r_digit <= i_load_val;
    end else if (i_adv && i_cin) begin
      r_digit <= i_up ? r_digit + 1'b1 : r_digit - 1'b1;
    end
  end

  // Ripple only when this cell is about to wrap in the current direction.
  assign o_cout  = i_cin && (i_up ? (r_digit == DIGIT_MAX) : (r_digit == '0));
  assign o_digit = r_digit;
endmodule

// File: rtl/hex_counter.sv
// Multi-digit hex up/down counter with prescaled auto tick, synchronised step button and load.
// All outputs registered: tick/step advance visible the cycle Tick pulses, Step after 3 edges.
module hex_counter
  import display_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 50_000_000
) (
  input  logic                      Clock,
  input  logic                      Resetn,
  input  logic                      Enable,
  input  logic                      Up,
  input  logic                      Step,
  input  logic                      Load,
  input  logic [DIGIT_W*DIGITS-1:0] Valor,
  output logic [DIGIT_W*DIGITS-1:0] Digitos,
  output logic                      Tick,
  output logic                      Overflow
);
  localparam int PW = $clog2(PRESCALE);

  logic [PW-1:0] r_presc;
  logic          r_tick;
  logic          r_ovf;
  logic          r_step_s1;
  logic          r_step_s2;
  logic          r_step_prev;
  logic          w_term;
  logic          w_step_edge;
  logic          w_adv;
  logic [DIGITS:0] w_carry;

  // Terminal count is decoded combinationally so the digits move on the same edge Tick rises.
  assign w_term      = Enable && (r_presc == PW'(PRESCALE - 1));
  assign w_step_edge = r_step_s2 && !r_step_prev;
  assign w_adv       = w_term || w_step_edge;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_presc <= '0;
      r_tick  <= 1'b0;
    end else if (Load) begin
      r_presc <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_tick <= w_term;
      if (w_term) begin
        r_presc <= '0;
      end else if (Enable) begin
        r_presc <= r_presc + 1'b1;
      end
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_step_s1   <= 1'b0;
      r_step_s2   <= 1'b0;
      r_step_prev <= 1'b0;
    end else begin
      r_step_s1   <= Step;
      r_step_s2   <= r_step_s1;
      r_step_prev <= r_step_s2;
    end
  end

  assign w_carry[0] = w_adv;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    hex_digit u_digit (
      .Clock      (Clock),
      .Resetn     (Resetn),
      .i_load     (Load),
      .i_load_val (Valor[DIGIT_W*g +: DIGIT_W]),
      .i_adv      (w_adv),
      .i_up       (Up),
      .i_cin      (w_carry[g]),
      .o_digit    (Digitos[DIGIT_W*g +: DIGIT_W]),
      .o_cout     (w_carry[g+1])
    );
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_ovf <= 1'b0;
    end else begin
      r_ovf <= !Load && w_carry[DIGITS];
    end
  end

  assign Tick     = r_tick;
  assign Overflow = r_ovf;
endmodule

// File: tb/tb_hex_counter.sv
// Bench for hex_counter (DIGITS=4, PRESCALE=4): hand sequences, vector table and random run vs model.
module tb_hex_counter;
  localparam int DIGITS   = 4;
  localparam int PRESCALE = 4;
  localparam int NW       = 4 * DIGITS;
  localparam int MODULUS  = 1 << NW;

  logic          Clock = 1'b0;
  logic          Resetn;
  logic          Enable;
  logic          Up;
  logic          Step;
  logic          Load;
  logic [NW-1:0] Valor;
  logic [NW-1:0] Digitos;
  logic          Tick;
  logic          Overflow;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  // Reference state: count as an integer, enabled cycles since last tick/load, Step samples.
  int m_val;
  int m_cnt;
  bit m_tick;
  bit m_ovf;
  bit m_hist [1:3];

  hex_counter #(.DIGITS(DIGITS), .PRESCALE(PRESCALE)) dut (
    .Clock    (Clock),
    .Resetn   (Resetn),
    .Enable   (Enable),
    .Up       (Up),
    .Step     (Step),
    .Load     (Load),
    .Valor    (Valor),
    .Digitos  (Digitos),
    .Tick     (Tick),
    .Overflow (Overflow)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [15:0] load_val;
    bit          up;
    int          n_cycles;
    logic [15:0] exp_val;
    int          exp_ovf;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", name, cycle, act, exp);
    end
  endtask

  task automatic model_reset();
    m_val = 0;
    m_cnt = 0;
    m_tick = 0;
    m_ovf = 0;
    for (int i = 1; i <= 3; i++) m_hist[i] = 0;
  endtask

  // Step sampled at edge k (after a low sample at k-1) advances the count at edge k+2.
  task automatic model_edge();
    bit step_adv;
    int nv;
    step_adv = m_hist[2] && !m_hist[3];
    m_tick = 0;
    m_ovf  = 0;
    if (Load) begin
      m_val = int'(Valor);
      m_cnt = 0;
    end else begin
      if (Enable) begin
        m_cnt++;
        if (m_cnt == PRESCALE) begin
          m_cnt  = 0;
          m_tick = 1;
        end
      end
      if (m_tick || step_adv) begin
        nv    = m_val + (Up ? 1 : -1);
        m_ovf = (nv < 0) || (nv >= MODULUS);
        m_val = (nv + MODULUS) % MODULUS;
      end
    end
    m_hist[3] = m_hist[2];
    m_hist[2] = m_hist[1];
    m_hist[1] = Step;
  endtask

  task automatic cyc();
    model_edge();
    @(posedge Clock);
    #1;
    cycle++;
    chk("model_digitos", 32'(Digitos), m_val);
    chk("model_tick", 32'(Tick), 32'(m_tick));
    chk("model_overflow", 32'(Overflow), 32'(m_ovf));
  endtask

  initial begin
    vec_t vecs [7];
    int ticks, last_tick, ovfs;

    vecs[0] = '{16'hFFFE, 1'b1,  8, 16'h0000, 1};
    vecs[1] = '{16'h0000, 1'b0,  4, 16'hFFFF, 1};
    vecs[2] = '{16'h0FFF, 1'b1,  4, 16'h1000, 0};
    vecs[3] = '{16'h1000, 1'b0,  4, 16'h0FFF, 0};
    vecs[4] = '{16'h00FF, 1'b1,  8, 16'h0101, 0};
    vecs[5] = '{16'hABCD, 1'b0, 12, 16'hABCA, 0};
    vecs[6] = '{16'h0001, 1'b0,  8, 16'hFFFF, 1};

    Resetn = 1'b0; Enable = 1'b0; Up = 1'b1; Step = 1'b0; Load = 1'b0; Valor = '0;
    model_reset();
    #12;
    chk("reset_digitos", 32'(Digitos), 32'h0);
    chk("reset_tick", 32'(Tick), 32'h0);
    chk("reset_overflow", 32'(Overflow), 32'h0);
    @(negedge Clock);
    Resetn = 1'b1;

    // Auto count from zero: 10 ticks, 4 cycles apart.
    Enable = 1'b1; Up = 1'b1;
    ticks = 0; last_tick = -1;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (Tick) begin
        if (last_tick >= 0) chk("tick_gap", 32'(i - last_tick), 32'd4);
        last_tick = i;
        ticks++;
      end
    end
    chk("auto_ticks", 32'(ticks), 32'd10);
    chk("auto_digitos", 32'(Digitos), 32'h000A);

    // Asynchronous reset between edges clears everything at once.
    for (int i = 0; i < 6; i++) cyc();
    #3;
    Resetn = 1'b0;
    #1;
    chk("midreset_digitos", 32'(Digitos), 32'h0);
    chk("midreset_tick", 32'(Tick), 32'h0);
    chk("midreset_overflow", 32'(Overflow), 32'h0);
    model_reset();
    @(negedge Clock);
    Resetn = 1'b1;

    foreach (vecs[v]) begin
      Load = 1'b1; Valor = vecs[v].load_val; Up = vecs[v].up; Enable = 1'b1;
      cyc();
      Load = 1'b0;
      ovfs = 0;
      for (int i = 0; i < vecs[v].n_cycles; i++) begin
        cyc();
        if (Overflow) ovfs++;
      end
      chk($sformatf("vec%0d_digitos", v), 32'(Digitos), 32'(vecs[v].exp_val));
      chk($sformatf("vec%0d_overflows", v), 32'(ovfs), 32'(vecs[v].exp_ovf));
    end

    // Manual step while paused: one advance, third edge after the rise, prescaler held.
    Load = 1'b1; Valor = 16'h0100; Enable = 1'b1; Up = 1'b1;
    cyc();
    Load = 1'b0;
    cyc();
    cyc();
    Enable = 1'b0; Step = 1'b1;
    cyc(); chk("step_e1", 32'(Digitos), 32'h0100);
    cyc(); chk("step_e2", 32'(Digitos), 32'h0100);
    cyc(); chk("step_e3", 32'(Digitos), 32'h0101);
    for (int i = 0; i < 7; i++) cyc();
    chk("step_hold", 32'(Digitos), 32'h0101);
    Step = 1'b0; Enable = 1'b1;
    cyc(); chk("step_presc_notick", 32'(Tick), 32'h0);
    cyc(); chk("step_presc_tick", 32'(Tick), 32'h1);
    chk("step_presc_digitos", 32'(Digitos), 32'h0102);

    // Tick and step edge on the same edge: a single advance.
    Load = 1'b1; Valor = 16'h0010;
    cyc();
    Load = 1'b0;
    cyc();
    Step = 1'b1;
    cyc();
    cyc();
    cyc();
    chk("coinc_tick", 32'(Tick), 32'h1);
    chk("coinc_digitos", 32'(Digitos), 32'h0011);
    Step = 1'b0;
    cyc(); cyc(); cyc();

    // Load beats a coincident tick, step edge and would-be wrap.
    Load = 1'b1; Valor = 16'hFFFF;
    cyc();
    Load = 1'b0;
    cyc();
    Step = 1'b1;
    cyc();
    cyc();
    Load = 1'b1; Valor = 16'h1234;
    cyc();
    chk("prio_digitos", 32'(Digitos), 32'h1234);
    chk("prio_tick", 32'(Tick), 32'h0);
    chk("prio_overflow", 32'(Overflow), 32'h0);
    Load = 1'b0;
    ticks = 0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (Tick) ticks++;
    end
    chk("prio_quiet", 32'(ticks), 32'h0);
    cyc();
    chk("prio_next_tick", 32'(Tick), 32'h1);
    chk("prio_next_digitos", 32'(Digitos), 32'h1235);
    Step = 1'b0;

    for (int i = 0; i < 3000; i++) begin
      Load   = ($urandom_range(15) == 0);
      Valor  = 16'($urandom);
      Enable = ($urandom_range(3) != 0);
      Up     = 1'($urandom);
      if ($urandom_range(3) == 0) Step = ~Step;
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hex_counter.md
# hex_counter

Multi-digit hexadecimal up/down counter that produces the 4-bit nibbles feeding the per-digit 7-segment decoders, one nibble per `display` instance. A prescaler derives a slow count tick from the board clock. A synchronised push-button input allows manual single-stepping, and a synchronous load presets the value. The block sits directly upstream of the 7-segment decoder stage; `Digitos[4*i+3:4*i]` drives the `Entrada` of decoder *i*.

## Interface
Parameters:
- `DIGITS`, 4: number of hex digits (1..8).
- `PRESCALE`, 50_000_000: clock cycles per automatic count tick (≥2); 1 Hz at 50 MHz.

Ports:
- `Clock`  in  1  system clock; single clock domain.
- `Resetn`  in  1  reset; asynchronous and active-low.
- `Enable`  in  1  run automatic counting; low freezes the prescaler.
- `Up`  in  1  1 = increment, 0 = decrement; sampled on each advance.
- `Step`  in  1  asynchronous push-button, active-high; each rising edge advances the count by one.
- `Load`  in  1  synchronous preset strobe.
- `Valor`  in  4*DIGITS  preset value; digit 0 is in bits [3:0].
- `Digitos`  out  4*DIGITS  current count; digit *i* is in bits [4i+3:4i].
- `Tick`  out  1  one-cycle pulse on each prescaler terminal count.
- `Overflow`  out  1  one-cycle pulse on wrap-around in either direction.

## Operation
- Reset (async, `Resetn`=0): `Digitos`=0, `Tick`=0, `Overflow`=0, prescaler=0, Step synchroniser flops=0. Release is synchronous to `Clock`.
- Prescaler: counts 0..PRESCALE-1 while `Enable`=1 and holds its value while `Enable`=0. At PRESCALE-1 it wraps to 0 and `Tick`=1 for that cycle.
- Step path: 2-FF synchroniser, then an edge register. `step_edge` = sync & ~prev.
- Advance condition: `adv` = `Tick` | `step_edge`. Coincident Tick and step_edge produce one advance, not two.
- Each digit is a mod-16 cell. Increment carries into the next digit when the current digit = F. Decrement borrows when the current digit = 0.
- Wrap-around:
  - Up from all-F: result is all-0 and `Overflow`=1.
  - Down from all-0: result is all-F and `Overflow`=1.
- `Load` has highest priority: `Digitos`←`Valor`, prescaler←0, and `Tick`, `Overflow` are suppressed that cycle. Any coincident advance is discarded.
- The `Up` value sampled at an advance edge applies to that advance. Changing `Up` between advances has no other effect.
- `Enable` does not gate `Step`. Manual stepping works while paused.

## Timing
- All outputs are registered. Nothing is combinational from input to output.
- `Tick` is asserted in the same cycle that the new `Digitos` value appears:
  - The prescaler reaches PRESCALE-1.
  - On the next edge, `Tick`=1 and `Digitos` is updated together.
  - Tick period is exactly PRESCALE cycles with `Enable` held high.
- `Step` rising before edge k updates `Digitos` at edge k+2 (3-edge latency, including the synchroniser). Holding `Step` high gives exactly one advance.
- `Load` sampled at edge k gives `Digitos`=`Valor` after edge k. The first automatic tick follows PRESCALE enabled cycles later.
- `Overflow` is high for exactly the cycle in which the wrapped value is first visible.
- Reset asserted mid-count clears everything immediately, regardless of `Clock`.

## Structure
- Shared package `display_pkg`:
  - `DIGIT_W`=4.
  - The nibble typedef `digit_t`.
  - This block and the decoder both use them.
- Prescaler width: $clog2(PRESCALE).
- One sub-module `hex_digit`:
  - Inputs: `Clock`, `Resetn`, load, load value, adv, up, carry-in.
  - Outputs: digit, carry-out.
  - Instantiated DIGITS times in a generate chain.
  - Digit 0 carry-in = adv. `Overflow` = final carry-out registered.
- Prescaler and Step synchroniser are inline in the top module.

## Test plan
(PRESCALE=4, DIGITS=4)
- Reset: assert `Resetn`=0 mid-count → `Digitos`=0x0000, `Tick`=0, `Overflow`=0 immediately.
- Auto count: `Enable`=1, `Up`=1 for 40 cycles from 0 → 10 `Tick` pulses 4 cycles apart, `Digitos`=0x000A.
- Up wrap: `Load` 0xFFFE, `Up`=1, `Enable`=1 → 0xFFFF, then 0x0000 with `Overflow`=1 for one cycle. Down from 0x0000 → 0xFFFF with `Overflow`=1.
- Carry/borrow chain:
  - `Load` 0x0FFF, then one up-tick → 0x1000.
  - `Load` 0x1000, then one down-tick → 0x0FFF.
- Step: `Enable`=0, `Step` high for 10 cycles → exactly one advance, 3 edges after the rise. The prescaler value is unchanged.
- Priority:
  - `Load` 0x1234 coincident with `Tick` and step_edge → `Digitos`=0x1234, no `Overflow`, next tick 4 cycles later.
  - Tick coincident with step_edge → single advance.
